// File: rtl/execute.sv
// -----------------------------------------------------------------------------
// execute -- EX stage of the 5-stage MIPS pipeline.
//
// Computes the ALU result, zero flag, branch target and destination register
// from the ID/EX operands and registers them into the EX/MEM latch feeding
// the memory stage. R-type funct 011000 (mult) runs an iterative shift-add
// multiplier for MUL_CYCLES cycles. The front of the pipe is stalled during
// that time, and the latch carries bubbles until the product is written.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   wb_ctrl, m_ctrl          writeback / memory control (m_ctrl = {branch,
//                            mem_read, mem_write}), passed to the latch
//   reg_dst, alu_src, alu_op destination select, operand-B select, ALU op
//   npc, read_data1/2        PC+4 and register operands
//   sign_ext                 sign-extended immediate (funct = sign_ext[5:0])
//   rt, rd                   candidate destination registers
//   stall                    high while a multiply is in progress
//   wb_ctrl_out .. write_reg EX/MEM latch contents
// -----------------------------------------------------------------------------
module execute #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       wb_ctrl,
  input  logic [2:0]       m_ctrl,
  input  logic             reg_dst,
  input  logic             alu_src,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] sign_ext,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  output logic             stall,
  output logic [1:0]       wb_ctrl_out,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] add_result,
  output logic             zero,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] write_data,
  output logic [4:0]       write_reg
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(MUL_CYCLES - 1);

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MULT = 6'b011000;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_comb;
  logic [WIDTH-1:0] branch_target;
  logic [4:0]       dest_reg;
  logic [5:0]       funct;
  logic             is_mult;

  // Multiplier working registers; only these (never the live inputs) are
  // used while in MUL.
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mul_sum;
  logic [CW-1:0]    count;
  logic             mul_last;
  logic [1:0]       held_wb;
  logic [4:0]       held_reg;

  assign funct         = sign_ext[5:0];
  assign op_b          = alu_src ? sign_ext : read_data2;
  assign dest_reg      = reg_dst ? rd : rt;
  assign branch_target = npc + (sign_ext << 2);

  // Sum of the current iteration; on the last iteration this is the product.
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (count == LAST_ITER);

  // ALU. mult produces nothing here; its result comes from the accumulator.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    alu_comb = '0;
    is_mult  = 1'b0;
    case (alu_op)
      2'b01: alu_comb = read_data1 - op_b;
      2'b10: begin
        case (funct)
          F_ADD:   alu_comb = read_data1 + op_b;
          F_SUB:   alu_comb = read_data1 - op_b;
          F_AND:   alu_comb = read_data1 & op_b;
          F_OR:    alu_comb = read_data1 | op_b;
          F_SLT:   alu_comb = ($signed(read_data1) < $signed(op_b)) ? WIDTH'(1) : '0;
          F_MULT:  is_mult  = 1'b1;
          default: alu_comb = '0;
        endcase
      end
      default: alu_comb = read_data1 + op_b;  // 00 add, 11 reserved -> add
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= next_state;
    end
  end

  // FSM next state and stall. stall rises in the same cycle a mult is
  // decoded and falls combinationally once IDLE is re-entered.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (is_mult) begin
          stall      = 1'b1;
          next_state = MUL;
        end
      end
      MUL: begin
        stall = 1'b1;
        if (mul_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  // Multiplier datapath and EX/MEM latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      count       <= '0;
      held_wb     <= '0;
      held_reg    <= '0;
      wb_ctrl_out <= '0;
      branch      <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      add_result  <= '0;
      zero        <= 1'b1;  // alu_result is 0 in reset
      alu_result  <= '0;
      write_data  <= '0;
      write_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mult) begin
            // Capture operands and the instruction's writeback identity;
            // the latch takes a bubble (data fields left as they were).
            mcand       <= read_data1;
            mplier      <= op_b;
            acc         <= '0;
            count       <= '0;
            held_wb     <= wb_ctrl;
            held_reg    <= dest_reg;
            wb_ctrl_out <= '0;
            branch      <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
          end else begin
            wb_ctrl_out <= wb_ctrl;
            branch      <= m_ctrl[2];
            mem_read    <= m_ctrl[1];
            mem_write   <= m_ctrl[0];
            add_result  <= branch_target;
            zero        <= (alu_comb == '0);
            alu_result  <= alu_comb;
            write_data  <= read_data2;
            write_reg   <= dest_reg;
          end
        end
        MUL: begin
          acc       <= mul_sum;
          mcand     <= mcand << 1;
          mplier    <= mplier >> 1;
          count     <= count + CW'(1);
          branch    <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (mul_last) begin
            alu_result  <= mul_sum;
            zero        <= (mul_sum == '0);
            wb_ctrl_out <= held_wb;
            write_reg   <= held_reg;
          end else begin
            wb_ctrl_out <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute.sv
// -----------------------------------------------------------------------------
// tb_execute -- directed bench for the EX stage. Expected latch contents are
// pushed to a scoreboard when an instruction is driven and popped when the
// EX/MEM latch is sampled (1 time unit after the rising edge).
// -----------------------------------------------------------------------------
module tb_execute;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 32;

  logic             clk;
  logic             rst;
  logic [1:0]       wb_ctrl;
  logic [2:0]       m_ctrl;
  logic             reg_dst;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] npc;
  logic [WIDTH-1:0] read_data1;
  logic [WIDTH-1:0] read_data2;
  logic [WIDTH-1:0] sign_ext;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic             stall;
  logic [1:0]       wb_ctrl_out;
  logic             branch;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] add_result;
  logic             zero;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] write_data;
  logic [4:0]       write_reg;

  execute #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_ctrl    (wb_ctrl),
    .m_ctrl     (m_ctrl),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .npc        (npc),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .sign_ext   (sign_ext),
    .rt         (rt),
    .rd         (rd),
    .stall      (stall),
    .wb_ctrl_out(wb_ctrl_out),
    .branch     (branch),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .add_result (add_result),
    .zero       (zero),
    .alu_result (alu_result),
    .write_data (write_data),
    .write_reg  (write_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic        br;
    logic        mr;
    logic        mw;
    logic [31:0] add;
    logic        zf;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    bit          data_valid;  // add_result / write_data are defined
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic rdst,
                       input logic asrc, input logic [1:0] op, input logic [31:0] pc4,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                       input logic [4:0] rt_i, input logic [4:0] rd_i);
    wb_ctrl    = wb;
    m_ctrl     = m;
    reg_dst    = rdst;
    alu_src    = asrc;
    alu_op     = op;
    npc        = pc4;
    read_data1 = a;
    read_data2 = b;
    sign_ext   = se;
    rt         = rt_i;
    rd         = rd_i;
  endtask

  task automatic push_exp(input string tag, input logic [1:0] wb, input logic [2:0] m,
                          input logic [31:0] add, input logic zf, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] wr, input bit dv);
    exp_t e;
    e.wb = wb; e.br = m[2]; e.mr = m[1]; e.mw = m[0];
    e.add = add; e.zf = zf; e.alu = alu; e.wd = wd; e.wr = wr; e.data_valid = dv;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic compare_latch();
    exp_t  e;
    string t;
    check("scoreboard_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    t = sb_tag.pop_front();
    check({t, " wb_ctrl_out"}, 32'(wb_ctrl_out), 32'(e.wb));
    check({t, " m_ctrl_out"}, 32'({branch, mem_read, mem_write}), 32'({e.br, e.mr, e.mw}));
    check({t, " zero"}, 32'(zero), 32'(e.zf));
    check({t, " alu_result"}, alu_result, e.alu);
    check({t, " write_reg"}, 32'(write_reg), 32'(e.wr));
    if (e.data_valid) begin
      check({t, " add_result"}, add_result, e.add);
      check({t, " write_data"}, write_data, e.wd);
    end
  endtask

  task automatic drive_nop();
    drive(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
  endtask

  // Presents a mult at posedge+1 and follows it to the result. The end of
  // the multiply is detected by the latch showing a non-bubble wb_ctrl_out,
  // so wb must be non-zero.
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd_i, input logic [1:0] wb,
                          input logic [31:0] prod, input logic prod_zero);
    int cycles;
    bit done;
    drive(wb, 3'b011, 1'b1, 1'b0, 2'b10, 32'h0, a, b, 32'h18, 5'd1, rd_i);
    push_exp(tag, wb, 3'b000, 32'h0, prod_zero, prod, 32'h0, rd_i, 1'b0);
    #1 check({tag, " stall_on_decode"}, 32'(stall), 32'd1);
    cycles = 1;
    done   = 1'b0;
    for (int k = 0; k < MUL_CYCLES + 8 && !done; k++) begin
      @(posedge clk);
      #1;
      if (wb_ctrl_out != 2'b00) begin
        done = 1'b1;
      end else begin
        check({tag, " bubble"}, 32'({stall, wb_ctrl_out, branch, mem_read, mem_write}),
              32'b10_0000);
        cycles++;
      end
    end
    check({tag, " stall_cycles"}, 32'(cycles), 32'(MUL_CYCLES + 1));
    compare_latch();
    drive_nop();
    #1 check({tag, " stall_released"}, 32'(stall), 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic [5:0]  funct;
    logic [1:0]  op;
    logic [2:0]  m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu;
    logic [31:0] add;
  } rtype_t;

  rtype_t rtab[$];

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // R-type / reserved-op table; npc = 0x100, so add_result = 0x100 + funct*4.
    rtab.push_back('{"add_wrap",   6'h20, 2'b10, 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h0000_0180});
    rtab.push_back('{"sub_wrap",   6'h22, 2'b10, 3'b000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0188});
    rtab.push_back('{"and",        6'h24, 2'b10, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0000_0190});
    rtab.push_back('{"or",         6'h25, 2'b10, 3'b000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h0000_0194});
    rtab.push_back('{"slt_neg",    6'h2A, 2'b10, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_01A8});
    rtab.push_back('{"slt_swap",   6'h2A, 2'b10, 3'b000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_01A8});
    rtab.push_back('{"bad_funct",  6'h3F, 2'b10, 3'b001, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_01FC});
    rtab.push_back('{"op11_add",   6'h00, 2'b11, 3'b000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 32'h0000_0100});

    rst = 1'b1;
    drive_nop();
    #2;
    push_exp("reset_initial", 2'b00, 3'b000, 32'h0, 1'b1, 32'h0, 32'h0, 5'd0, 1'b1);
    compare_latch();
    check("reset_initial stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Add immediate.
    drive(2'b01, 3'b010, 1'b0, 1'b1, 2'b00, 32'h0, 32'h4, 32'h55, 32'h8, 5'd2, 5'd5);
    push_exp("addi", 2'b01, 3'b010, 32'h20, 1'b0, 32'hC, 32'h55, 5'd2, 1'b1);
    @(posedge clk);
    #1 compare_latch();

    // Asynchronous reset in the middle of a cycle.
    #3 rst = 1'b1;
    #1;
    push_exp("reset_async", 2'b00, 3'b000, 32'h0, 1'b1, 32'h0, 32'h0, 5'd0, 1'b1);
    compare_latch();
    check("reset_async stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Branch compare via sub.
    drive(2'b00, 3'b100, 1'b1, 1'b0, 2'b01, 32'h10, 32'h1234_5678, 32'h1234_5678,
          32'hFFFF_FFFF, 5'd3, 5'd7);
    push_exp("beq_sub", 2'b00, 3'b100, 32'hC, 1'b1, 32'h0, 32'h1234_5678, 5'd7, 1'b1);
    @(posedge clk);
    #1 compare_latch();

    // R-type sweep.
    foreach (rtab[i]) begin
      drive(2'b10, rtab[i].m, 1'b1, 1'b0, rtab[i].op, 32'h100, rtab[i].a, rtab[i].b,
            32'(rtab[i].funct), 5'd4, 5'(i + 8));
      push_exp(rtab[i].tag, 2'b10, rtab[i].m, rtab[i].add, rtab[i].alu == 32'h0,
               rtab[i].alu, rtab[i].b, 5'(i + 8), 1'b1);
      @(posedge clk);
      #1 compare_latch();
    end

    // Multiplies, the second starting right after the first completes.
    run_mult("mult", 32'h0000_1234, 32'h0000_0010, 5'd9, 2'b11, 32'h0001_2340, 1'b0);
    run_mult("mult_zero", 32'h0001_0000, 32'h0001_0000, 5'd10, 2'b01, 32'h0000_0000, 1'b1);
    run_mult("mult_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 2'b10, 32'h0000_0001, 1'b0);

    // Reset at MUL iteration 10, then a normal add.
    drive(2'b11, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h7, 32'h3, 32'h18, 5'd1, 5'd12);
    repeat (11) @(posedge clk);
    #3 rst = 1'b1;
    drive(2'b01, 3'b000, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1, 32'h1, 32'h0, 5'd4, 5'd0);
    #1;
    push_exp("reset_mid_mult", 2'b00, 3'b000, 32'h0, 1'b1, 32'h0, 32'h0, 5'd0, 1'b1);
    compare_latch();
    check("reset_mid_mult stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    push_exp("add_after_reset", 2'b01, 3'b000, 32'h0, 1'b0, 32'h2, 32'h1, 5'd4, 1'b1);
    @(posedge clk);
    #1 compare_latch();
    check("add_after_reset stall", 32'(stall), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- EX stage of the 5-stage MIPS pipeline, directly upstream of the `memory` stage.
- Consumes the decoded operands and control from ID/EX. Computes the ALU result, zero flag, branch target and destination register.
- Registers everything into the EX/MEM pipeline latch that feeds `memory`.
- Adds an iterative shift-add multiplier (R-type funct 011000) that stalls the front of the pipe while busy.

Parameters:
- WIDTH, 32, datapath width in bits.
- MUL_CYCLES, 32, iterations of the multiplier. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wb_ctrl  input  2  writeback control. Passed through to the latch.
- m_ctrl  input  3  {branch, mem_read, mem_write}. Passed through to the latch.
- reg_dst  input  1  1: destination is rd; 0: destination is rt.
- alu_src  input  1  1: operand B is sign_ext; 0: operand B is read_data2.
- alu_op  input  2  00 add, 01 sub, 10 decode funct, 11 reserved (treated as add).
- npc  input  WIDTH  PC+4 of the instruction.
- read_data1  input  WIDTH  operand A.
- read_data2  input  WIDTH  operand B / store data.
- sign_ext  input  WIDTH  sign-extended immediate; funct is sign_ext[5:0].
- rt  input  5  instr[20:16].
- rd  input  5  instr[15:11].
- stall  output  1  high while the multiplier is busy. Upstream holds PC and ID/EX.
- wb_ctrl_out  output  2  latched wb_ctrl.
- branch  output  1  latched.
- mem_read  output  1  latched.
- mem_write  output  1  latched.
- add_result  output  WIDTH  latched branch target.
- zero  output  1  latched (alu_result == 0).
- alu_result  output  WIDTH  latched ALU/multiply result.
- write_data  output  WIDTH  latched read_data2 (store data).
- write_reg  output  5  latched destination register.

Behaviour:
- Reset (asynchronous, any time, including mid-multiply):
  - All outputs go to 0, except zero, which goes to 1 because alu_result is 0.
  - FSM goes to IDLE and the iteration counter goes to 0.
- Operand B = alu_src ? sign_ext : read_data2.
- write_reg = reg_dst ? rd : rt.
- Branch target: add_result = npc + (sign_ext << 2), modulo 2^WIDTH; carry is discarded.
- Funct decode when alu_op = 10:
  - 100000 add; 100010 sub; 100100 and; 100101 or.
  - 101010 slt: signed compare, result 1 or 0.
  - 011000 mult: low WIDTH bits of the unsigned product.
  - Any other funct: result 0, controls still passed.
- Add and sub wrap modulo 2^WIDTH. No overflow trap.
- FSM states: IDLE and MUL.
- IDLE, non-mult instruction:
  - Single-cycle latency. The whole EX/MEM latch loads on the next rising edge.
  - stall = 0.
- IDLE, mult decoded (combinational):
  - stall goes high in the same cycle.
  - On the edge: capture multiplicand/multiplier, clear the accumulator and counter, go to MUL.
  - On that edge the latch loads a bubble: wb_ctrl_out, branch, mem_read, mem_write = 0. Data fields are don't-care.
- MUL, every cycle:
  - If multiplier bit 0 is 1, accumulator += multiplicand.
  - Multiplicand shifts left 1; multiplier shifts right 1; counter increments.
  - stall = 1 and the latch keeps loading bubbles.
- MUL, final iteration:
  - When the counter reaches MUL_CYCLES-1, the iteration's sum is written to alu_result on that edge.
  - wb_ctrl_out, write_reg and zero come from the held mult instruction. m_ctrl outputs are forced to 0.
  - FSM returns to IDLE; stall drops combinationally for the next cycle.
- Mult timing: stall is high for exactly MUL_CYCLES+1 cycles. The result appears in the latch MUL_CYCLES+1 edges after the mult is presented.
- Upstream inputs are stable while stall = 1. The block uses only captured copies during MUL.
- Back-to-back mults: the second begins in the cycle after IDLE is re-entered.
- zero is computed from the final value being latched, including mult results.

Test Plan:
- Reset:
  - Assert rst mid-cycle -> all outputs 0 and zero = 1 immediately (asynchronous), stall = 0.
- Add immediate:
  - alu_op=00, alu_src=1, read_data1=0x00000004, sign_ext=0x00000008, reg_dst=0, rt=2, wb_ctrl=01, m_ctrl=010.
  - Expect, one edge later: alu_result=0x0000000C, write_reg=2, mem_read=1, zero=0.
- Branch sub:
  - alu_op=01, read_data1=read_data2=0x12345678, npc=0x00000010, sign_ext=0xFFFFFFFF, m_ctrl=100.
  - Expect zero=1, branch=1, add_result=0x0000000C.
- Signed slt:
  - funct 101010, read_data1=0xFFFFFFFF, read_data2=0x00000001.
  - Expect alu_result=1; swapped operands give 0.
- Multiply:
  - funct 011000, read_data1=0x00001234, read_data2=0x00000010.
  - Expect stall high 33 cycles and the latch showing bubbles meanwhile.
  - Then alu_result=0x00012340, wb_ctrl_out restored, stall=0.
- Reset mid-multiply:
  - Assert rst at MUL iteration 10 -> stall=0, outputs 0.
  - A following add 1+1 completes normally -> alu_result=2.
